// File: rtl/opfetch_pkg.sv
// opfetch_pkg: state codes, instruction field positions and field helpers for operand_fetch
package opfetch_pkg;
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, HOLD = 2'd2;
  localparam int RS_HI = 25, RS_LO = 21, RT_HI = 20, RT_LO = 16, RD_HI = 15, RD_LO = 11;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic logic [4:0] rs_of(input logic [31:0] i);
    return i[RS_HI:RS_LO];
  endfunction
  function automatic logic [4:0] rt_of(input logic [31:0] i);
    return i[RT_HI:RT_LO];
  endfunction
  function automatic logic [4:0] rd_of(input logic [31:0] i);
    return i[RD_HI:RD_LO];
  endfunction
endpackage

// File: rtl/operand_fwd.sv
// operand_fwd: one resolved operand with writeback forwarding and zero forcing (forwarding under OPFETCH_FWD_EN)
module operand_fwd
  import opfetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        accept,
  input  logic        reading,
  input  logic        holding,
  input  logic [4:0]  src_in,
  input  logic [4:0]  src_q,
  input  logic [31:0] rf_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] val
);
`ifdef OPFETCH_FWD_EN
  logic        pend;
  logic [31:0] pend_data;
  logic        live;
  assign live = wb_en && wb_addr == src_q && src_q != REG_ZERO;
  // remember a writeback to the incoming source on the accept edge, since the regfile reads the old value then
  always_ff @(posedge clock)
    if (!reset) begin
      pend <= 1'b0;
      pend_data <= '0;
    end else if (accept) begin
      pend <= wb_en && wb_addr == src_in;
      pend_data <= wb_data;
    end
  // resolve the operand leaving READ (live > pending > regfile), then snoop writebacks while held
  always_ff @(posedge clock)
    if (!reset) val <= '0;
    else if (reading) val <= src_q == REG_ZERO ? '0 : live ? wb_data : pend ? pend_data : rf_data;
    else if (holding && live) val <= wb_data;
`else
  logic unused;
  assign unused = ^{accept, holding, src_in, wb_en, wb_addr, wb_data};
  // take the raw regfile data leaving READ, register 0 reads as zero
  always_ff @(posedge clock)
    if (!reset) val <= '0;
    else if (reading) val <= src_q == REG_ZERO ? '0 : rf_data;
`endif
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: decode-side operand fetch stage with regfile read and writeback forwarding (OPFETCH_FWD_EN)
module operand_fetch
  import opfetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_addra,
  output logic [4:0]  rf_addrb,
  input  logic [31:0] rf_dataa,
  input  logic [31:0] rf_datab,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs_val,
  output logic [31:0] out_rt_val
);
  logic [1:0] state;
  logic       accept, reading, holding;
  assign reading = state == READ;
  assign holding = state == HOLD;
  assign in_ready = reset && (state == IDLE || (holding && out_ready));
  assign accept = in_ready && in_valid;
  assign out_valid = holding;
  assign rf_addra = reading ? rs_of(out_instr) : rs_of(in_instr);
  assign rf_addrb = reading ? rt_of(out_instr) : rt_of(in_instr);
  // sequence IDLE/HOLD -> READ on accept, READ -> HOLD, HOLD -> IDLE when drained; latch the accepted word
  always_ff @(posedge clock)
    if (!reset) begin
      state <= IDLE;
      out_instr <= '0;
      out_pc <= '0;
    end else begin
      state <= accept ? READ : reading ? HOLD : holding && out_ready ? IDLE : state;
      if (accept) begin
        out_instr <= in_instr;
        out_pc <= in_pc;
      end
    end
  operand_fwd u_rs (
    .clock(clock), .reset(reset), .accept(accept), .reading(reading), .holding(holding),
    .src_in(rs_of(in_instr)), .src_q(rs_of(out_instr)), .rf_data(rf_dataa),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .val(out_rs_val)
  );
  operand_fwd u_rt (
    .clock(clock), .reset(reset), .accept(accept), .reading(reading), .holding(holding),
    .src_in(rt_of(in_instr)), .src_q(rt_of(out_instr)), .rf_data(rf_datab),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .val(out_rt_val)
  );
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scoreboard bench for operand_fetch with a registered-read regfile model
module tb_operand_fetch;
`ifdef OPFETCH_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct {
    logic [31:0] instr, pc, rs, rt;
  } exp_t;
  logic        clock, reset, in_valid, in_ready, wb_en, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rf_dataa, rf_datab, wb_data;
  logic [31:0] out_instr, out_pc, out_rs_val, out_rt_val;
  logic [4:0]  rf_addra, rf_addrb, wb_addr;
  logic [31:0] regs [32];
  exp_t        sb [$];
  int          total = 0, passed = 0;

  operand_fetch dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_addra(rf_addra), .rf_addrb(rf_addrb),
    .rf_dataa(rf_dataa), .rf_datab(rf_datab), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_rs_val(out_rs_val), .out_rt_val(out_rt_val)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] init_val(input int i);
    return i == 3 ? 32'h11 : i == 4 ? 32'h22 : 32'h1000_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'h05a};
  endfunction

  // register file model: registered read of the old contents, write on wb_en, preload on reset
  always @(posedge clock) begin
    if (!reset) for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
    else if (wb_en) regs[wb_addr] <= wb_data;
    rf_dataa <= regs[rf_addra];
    rf_datab <= regs[rf_addrb];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // pop the scoreboard on every output handshake
  always @(negedge clock)
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_output", out_instr, 32'hx);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_instr", out_instr, e.instr);
        check("sb_pc", out_pc, e.pc);
        check("sb_rs", out_rs_val, e.rs);
        check("sb_rt", out_rt_val, e.rt);
      end
    end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs,
                      input logic [31:0] rt, input bit push, output int waited);
    if (push) sb.push_back('{instr, pc, rs, rt});
    in_valid = 1'b1;
    in_instr = instr;
    in_pc = pc;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int w;
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_rs_val", out_rs_val, 32'd0);
    check("rst_rt_val", out_rt_val, 32'd0);
    reset = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    // basic fetch rs=3 rt=4
    send(mk(6'h01, 5'd3, 5'd4, 5'd9), 32'h100, 32'h11, 32'h22, 1'b1, w);
    check("read_in_ready", 32'(in_ready), 32'd0);
    check("read_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("latency_out_valid", 32'(out_valid), 32'd1);
    tick();
    // writeback to rs on the accept cycle
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hAAAA5555;
    send(mk(6'h02, 5'd5, 5'd6, 5'd1), 32'h200, FWD ? 32'hAAAA5555 : 32'h1000_0005, 32'h1000_0006, 1'b1, w);
    wb_en = 1'b0;
    repeat (2) tick();
    // accept-cycle write then a later write in READ
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h2;
    send(mk(6'h03, 5'd5, 5'd2, 5'd1), 32'h300, FWD ? 32'h1 : 32'hAAAA5555, 32'h1000_0002, 1'b1, w);
    wb_data = 32'h1;
    tick();
    wb_en = 1'b0;
    tick();
    // stall in HOLD with a snoop write to rt
    out_ready = 1'b0;
    send(mk(6'h04, 5'd8, 5'd7, 5'd2), 32'h400, 32'h1000_0008, FWD ? 32'hDEAD : 32'h1000_0007, 1'b1, w);
    tick();
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_in_ready1", 32'(in_ready), 32'd0);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD;
    tick();
    wb_en = 1'b0;
    check("snoop_rt", out_rt_val, FWD ? 32'hDEAD : 32'h1000_0007);
    check("snoop_rs_kept", out_rs_val, 32'h1000_0008);
    check("stall_instr", out_instr, mk(6'h04, 5'd8, 5'd7, 5'd2));
    check("stall_pc", out_pc, 32'h400);
    check("stall_in_ready2", 32'(in_ready), 32'd0);
    tick();
    check("stall_valid3", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    // register 0 sources with writes to r0
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    send(mk(6'h05, 5'd0, 5'd0, 5'd3), 32'h500, 32'd0, 32'd0, 1'b1, w);
    tick();
    wb_en = 1'b0;
    tick();
    // back-to-back through HOLD -> READ
    send(mk(6'h06, 5'd3, 5'd4, 5'd5), 32'h600, 32'h11, 32'h22, 1'b1, w);
    send(mk(6'h07, 5'd9, 5'd10, 5'd5), 32'h604, 32'h1000_0009, 32'h1000_000a, 1'b1, w);
    check("b2b_wait", 32'(w), 32'd1);
    repeat (2) tick();
    // reset during READ drops the instruction
    send(mk(6'h08, 5'd3, 5'd4, 5'd6), 32'h700, 32'h0, 32'h0, 1'b0, w);
    reset = 1'b0;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    tick();
    check("rst_mid_valid2", 32'(out_valid), 32'd0);
    send(mk(6'h09, 5'd11, 5'd3, 5'd7), 32'h800, 32'h1000_000b, 32'h11, 1'b1, w);
    w = 0;
    while (sb.size() != 0 && w < 50) begin
      tick();
      w++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-side operand fetch stage feeding the register file read ports and consuming its registered read data. Accepts one instruction word per handshake, drives rs/rt addresses to the register file, captures operands one cycle later with writeback forwarding, and holds a valid/ready output bundle for execute. Sits between instruction fetch and execute; snoops the same writeback bus that drives the register file write port.

## Interface
- Parameters: none (field positions in package).
- clock  in  1  rising-edge clock, shared with register file
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word; rs=[25:21], rt=[20:16], rd=[15:11]
- in_pc  in  32  PC of in_instr
- rf_addra  out  5  register file read address A (rs)
- rf_addrb  out  5  register file read address B (rt)
- rf_dataa  in  32  register file read data A, valid one cycle after address
- rf_datab  in  32  register file read data B, valid one cycle after address
- wb_en  in  1  writeback write enable (same net as register file write enable)
- wb_addr  in  5  writeback address
- wb_data  in  32  writeback data
- out_valid  out  1  operand bundle valid
- out_ready  in  1  execute accepts bundle
- out_instr, out_pc  out  32 each  held instruction/PC
- out_rs_val, out_rt_val  out  32 each  resolved operands

## Operation
- FSM states IDLE, READ, HOLD.
- IDLE: in_ready=1. On in_valid: latch instr/pc, go READ. rf_addra/rf_addrb driven combinationally from in_instr rs/rt so register file samples them on the accept edge.
- READ: in_ready=0, addresses driven from latched rs/rt. At the edge leaving READ: operand = rf_data unless forwarded; out_valid=1; go HOLD.
- Forwarding (per operand, independent): pending flag/data set at accept edge if wb_en and wb_addr==src; in READ, live wb match overrides pending; pending overrides rf_data.
- HOLD: out_valid=1. Each cycle, if wb_en and wb_addr matches a held source, that operand updates to wb_data (snoop). in_ready=out_ready. If out_ready: with in_valid, accept new instr and go READ; otherwise go IDLE, out_valid=0.
- Register 0: source 0 never forwarded or snooped; operand forced to 0 regardless of rf_data/wb.
- wb_en with wb_addr matching both rs and rt: both operands update.

## Timing
- Reset (reset=0 at edge): state IDLE, out_valid=0, out_instr/out_pc/out_rs_val/out_rt_val=0, pending flags clear. in_ready=0 while reset low.
- Latency: accept at edge E0 -> out_valid=1 after E1.
- Throughput: one instruction per 2 cycles (back-to-back via HOLD->READ).
- Outputs stable while out_valid=1 and out_ready=0, except operand snoop updates.
- Reset mid-READ/HOLD: in-flight instruction dropped, no output produced.

## Configuration
- OPFETCH_FWD_EN defined: forwarding at accept, forwarding in READ, and HOLD snoop as above.
- Undefined: operands are raw rf_data (register 0 still forced 0); no snoop; wb_* ports present but ignored. Hazard avoidance becomes upstream's responsibility.

## Structure
- opfetch_pkg: state enum (IDLE/READ/HOLD), field position constants (RS_HI/LO, RT_HI/LO, RD_HI/LO), REG_ZERO constant.
- One sub-module: operand_fwd (per-operand pending flag, select logic, zero forcing), instantiated twice (rs, rt).

## Test plan
- Reset with regfile r3=0x11, r4=0x22; in_instr rs=3 rt=4 -> out_valid after E1, out_rs_val=0x11, out_rt_val=0x22.
- Accept rs=5 while wb_en, wb_addr=5, wb_data=0xAAAA5555 on accept cycle -> out_rs_val=0xAAAA5555 (not stale rf value).
- In READ wb writes r5=0x1 after accept-cycle write r5=0x2 -> out_rs_val=0x1 (later write wins).
- out_ready=0 for 3 cycles, wb writes rt=7 with 0xDEAD in cycle 2 -> out_rt_val becomes 0xDEAD, out_instr/out_pc unchanged; in_ready=0 throughout.
- rs=0, rt=0, wb_en writing addr 0 data 0xFFFF -> both operands 0.
- Reset asserted in READ -> out_valid stays 0; next accepted instruction delivered normally; with OPFETCH_FWD_EN undefined, test 2 yields stale rf value.
